riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; wmask width is DATA_WIDTH/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while IFU waits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ifu_req_valid  input  1  IFU fetch request.
REQ-007 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-008 ifu_req_addr  input  ADDR_WIDTH  fetch address.
REQ-009 ifu_resp_valid  output  1  one-cycle pulse, fetch data valid.
REQ-010 ifu_resp_data  output  DATA_WIDTH  fetched word.
REQ-011 lsu_req_valid / lsu_req_ready  input / output  1 / 1  LSU request handshake.
REQ-012 lsu_req_addr / lsu_req_wen  input / input  ADDR_WIDTH / 1  address; 1 = store, 0 = load.
REQ-013 lsu_req_wdata / lsu_req_wmask  input / input  DATA_WIDTH / DATA_WIDTH/8  store data, byte strobes.
REQ-014 lsu_resp_valid / lsu_resp_data  output / output  1 / DATA_WIDTH  completion pulse; load data, 0 for stores.
REQ-015 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-016 mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  output  ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8  downstream request fields.
REQ-017 mem_resp_valid / mem_resp_data  input / input  1 / DATA_WIDTH  downstream completion; loads and stores both return exactly one.

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT; one outstanding transaction maximum.
REQ-019 IDLE: ifu_req_ready/lsu_req_ready SHALL be combinational, asserted only for the granted requester, only in IDLE; both 0 in REQ and WAIT.
REQ-020 Arbitration: LSU wins when both valid, unless the starvation counter equals STARVE_LIMIT, in which case IFU wins.
REQ-021 Starvation counter SHALL increment on each LSU grant while ifu_req_valid=1, clear on any IFU grant, saturate at STARVE_LIMIT.
REQ-022 On grant, IDLE->REQ; owner, addr, wen, wdata and wmask SHALL be registered; IFU grants register wen=0, wmask=0.
REQ-023 REQ: mem_req_valid=1 with registered fields held stable; on mem_req_ready=1 -> WAIT.
REQ-024 WAIT: mem_req_valid=0; on mem_resp_valid=1 -> IDLE, owner's resp_valid SHALL pulse the next cycle with resp_data = registered mem_resp_data (0 for stores).
REQ-025 A new grant MAY occur in the same cycle a resp_valid pulse is presented: request-to-request turnaround is one IDLE cycle.
REQ-026 mem_resp_valid in IDLE or REQ SHALL be ignored.
REQ-027 Minimum latency, upstream accept to resp_valid: 3 cycles (accept, REQ with mem_req_ready=1, WAIT with mem_resp_valid=1, pulse).
REQ-028 resp_data SHALL hold its value until the next response; resp_valid SHALL never be asserted for both requesters in one cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, starvation counter 0, mem_req_valid 0, both resp_valid 0, both resp_data 0, all registered request fields 0.
REQ-030 Reset mid-transaction SHALL drop the transaction with no response; a late mem_resp_valid after reset falls under REQ-026.

Verification
REQ-031 IFU only, addr 0x8000_0000, mem ready immediately, resp 0x0000_0413 next cycle -> ifu_resp_valid pulse with 0x0000_0413, 3 cycles after accept.
REQ-032 IFU and LSU load valid same cycle -> lsu_req_ready=1, ifu_req_ready=0; LSU served first, IFU granted next IDLE.
REQ-033 LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0011 -> mem fields match exactly; lsu_resp_data=0.
REQ-034 IFU continuously valid, LSU wins 4 back-to-back grants -> 5th grant goes to IFU, counter clears.
REQ-035 mem_req_ready held 0 for 5 cycles -> mem_req_* stable, both upstream readies 0 throughout.
REQ-036 rst_n deasserted in WAIT, then mem_resp_valid pulsed -> no resp_valid; all outputs at reset values.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction in flight.
// LSU has priority; a saturating counter hands the port to a waiting IFU after STARVE_LIMIT LSU wins.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]     ifu_req_addr,
    output logic                      ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]     ifu_resp_data,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_req_addr,
    input  logic                      lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   lsu_req_wmask,
    output logic                      lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]     lsu_resp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_wen,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_req_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_data,
    output logic [1:0]                dbg_state_o
);
    // Handshake: a request transfers in a cycle where valid && ready are both high at the
    // rising edge; upstream readies are combinational and only ever high in IDLE.
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  owner_lsu_q, owner_lsu_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0]     wmask_q, wmask_d;
    logic                  ifu_rv_q, ifu_rv_d;
    logic                  lsu_rv_q, lsu_rv_d;
    logic [DATA_WIDTH-1:0] ifu_rd_q, ifu_rd_d;
    logic [DATA_WIDTH-1:0] lsu_rd_q, lsu_rd_d;

    logic starved;
    logic grant_ifu;
    logic grant_lsu;

    assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (lsu_req_valid && !(ifu_req_valid && starved)) begin
                grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rv_d    = 1'b0;
        lsu_rv_d    = 1'b0;
        ifu_rd_d    = ifu_rd_q;
        lsu_rd_d    = lsu_rd_q;
        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    state_d     = REQ;
                    owner_lsu_d = 1'b1;
                    addr_d      = lsu_req_addr;
                    wen_d       = lsu_req_wen;
                    wdata_d     = lsu_req_wdata;
                    wmask_d     = lsu_req_wmask;
                    if (ifu_req_valid && !starved) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (grant_ifu) begin
                    state_d     = REQ;
                    owner_lsu_d = 1'b0;
                    addr_d      = ifu_req_addr;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    starve_d    = '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses outside WAIT are stray and never reach here.
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (owner_lsu_q) begin
                        lsu_rv_d = 1'b1;
                        lsu_rd_d = wen_q ? '0 : mem_resp_data;
                    end else begin
                        ifu_rv_d = 1'b1;
                        ifu_rd_d = mem_resp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_rd_q    <= '0;
            lsu_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
            ifu_rd_q    <= ifu_rd_d;
            lsu_rd_q    <= lsu_rd_d;
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_valid = ifu_rv_q;
    assign ifu_resp_data  = ifu_rd_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign lsu_resp_data  = lsu_rd_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomised bench for riscv_mem_arbiter: the driver issues traffic, a negedge monitor
// predicts grants, memory requests and responses from the arbitration rules and checks them.
module tb_riscv_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_wen;
    logic [DW-1:0] lsu_req_wdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [1:0]    dbg_state;

    riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .dbg_state_o(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // scoreboard state
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } mreq_t;

    mreq_t         exp_mem_q[$];
    logic [DW-1:0] exp_ifu_q[$];
    logic [DW-1:0] exp_lsu_q[$];
    int            m_starve = 0;
    bit            m_busy = 0;
    bit            m_issued = 0;
    bit            m_owner_lsu = 0;
    bit            m_wen = 0;
    logic [DW-1:0] last_ifu_d = '0;
    logic [DW-1:0] last_lsu_d = '0;

    // monitor / reference model
    always @(negedge clk) begin : monitor
        bit    busy_now, issued_now, exp_i, exp_l;
        mreq_t r;
        if (!rst_n) begin
            exp_mem_q.delete();
            exp_ifu_q.delete();
            exp_lsu_q.delete();
            m_starve = 0;
            m_busy = 0;
            m_issued = 0;
            last_ifu_d = '0;
            last_lsu_d = '0;
            chk("rst_state", dbg_state, 0);
            chk("rst_mem_valid", mem_req_valid, 0);
            chk("rst_ifu_rv", ifu_resp_valid, 0);
            chk("rst_lsu_rv", lsu_resp_valid, 0);
            chk("rst_ifu_rd", ifu_resp_data, 0);
            chk("rst_lsu_rd", lsu_resp_data, 0);
            chk("rst_mem_addr", mem_req_addr, 0);
            chk("rst_mem_wen", mem_req_wen, 0);
            chk("rst_mem_wdata", mem_req_wdata, 0);
            chk("rst_mem_wmask", mem_req_wmask, 0);
        end else begin
            busy_now = m_busy;
            issued_now = m_issued;
            chk("resp_exclusive", ifu_resp_valid && lsu_resp_valid, 0);
            chk("ifu_resp_valid", ifu_resp_valid, exp_ifu_q.size() > 0);
            if (exp_ifu_q.size() > 0) begin
                last_ifu_d = exp_ifu_q.pop_front();
                if (ifu_resp_valid) chk("ifu_resp_data", ifu_resp_data, last_ifu_d);
            end else if (!ifu_resp_valid) begin
                chk("ifu_resp_hold", ifu_resp_data, last_ifu_d);
            end
            chk("lsu_resp_valid", lsu_resp_valid, exp_lsu_q.size() > 0);
            if (exp_lsu_q.size() > 0) begin
                last_lsu_d = exp_lsu_q.pop_front();
                if (lsu_resp_valid) chk("lsu_resp_data", lsu_resp_data, last_lsu_d);
            end else if (!lsu_resp_valid) begin
                chk("lsu_resp_hold", lsu_resp_data, last_lsu_d);
            end

            chk("mem_req_valid", mem_req_valid, busy_now && !issued_now);
            if (busy_now && !issued_now && mem_req_valid && exp_mem_q.size() > 0) begin
                r = exp_mem_q[0];
                chk("mem_req_addr", mem_req_addr, r.addr);
                chk("mem_req_wen", mem_req_wen, r.wen);
                chk("mem_req_wdata", mem_req_wdata, r.wdata);
                chk("mem_req_wmask", mem_req_wmask, r.wmask);
                if (mem_req_ready) begin
                    exp_mem_q.delete(0);
                    m_issued = 1;
                end
            end

            if (busy_now && issued_now && mem_resp_valid) begin
                if (m_owner_lsu) exp_lsu_q.push_back(m_wen ? '0 : mem_resp_data);
                else exp_ifu_q.push_back(mem_resp_data);
                m_busy = 0;
                m_issued = 0;
            end

            exp_i = 0;
            exp_l = 0;
            if (!busy_now) begin
                if (lsu_req_valid && !(ifu_req_valid && m_starve == LIMIT)) exp_l = 1;
                else if (ifu_req_valid) exp_i = 1;
            end
            chk("ifu_req_ready", ifu_req_ready, exp_i);
            chk("lsu_req_ready", lsu_req_ready, exp_l);
            if (exp_l) begin
                r.addr = lsu_req_addr;
                r.wen = lsu_req_wen;
                r.wdata = lsu_req_wdata;
                r.wmask = lsu_req_wmask;
                exp_mem_q.push_back(r);
                m_owner_lsu = 1;
                m_wen = lsu_req_wen;
                m_busy = 1;
                m_issued = 0;
                if (ifu_req_valid && m_starve < LIMIT) m_starve++;
            end else if (exp_i) begin
                r.addr = ifu_req_addr;
                r.wen = 1'b0;
                r.wdata = '0;
                r.wmask = '0;
                exp_mem_q.push_back(r);
                m_owner_lsu = 0;
                m_wen = 0;
                m_busy = 1;
                m_issued = 0;
                m_starve = 0;
            end
        end
    end

    // driver
    int            p_ifu, p_lsu, p_ready, p_resp;
    bit            fix_en;
    logic [DW-1:0] fix_data;
    logic          ifu_acc, lsu_acc, ifu_rv, lsu_rv;
    logic [DW-1:0] ifu_rd_s, lsu_rd_s;

    task automatic tick();
        @(negedge clk);
        ifu_acc = ifu_req_valid && ifu_req_ready;
        lsu_acc = lsu_req_valid && lsu_req_ready;
        ifu_rv = ifu_resp_valid;
        lsu_rv = lsu_resp_valid;
        ifu_rd_s = ifu_resp_data;
        lsu_rd_s = lsu_resp_data;
        @(posedge clk);
        #1;
        if (ifu_acc) ifu_req_valid = 1'b0;
        if (lsu_acc) lsu_req_valid = 1'b0;
        if (!ifu_req_valid && $urandom_range(99) < p_ifu) begin
            ifu_req_valid = 1'b1;
            ifu_req_addr = $urandom;
        end
        if (!lsu_req_valid && $urandom_range(99) < p_lsu) begin
            lsu_req_valid = 1'b1;
            lsu_req_addr = $urandom;
            lsu_req_wen = 1'($urandom_range(1));
            lsu_req_wdata = $urandom;
            lsu_req_wmask = MW'($urandom_range(15));
        end
        mem_req_ready = ($urandom_range(99) < p_ready);
        mem_resp_valid = ($urandom_range(99) < p_resp);
        mem_resp_data = fix_en ? fix_data : $urandom;
    endtask

    task automatic set_lsu(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic [MW-1:0] m);
        lsu_req_valid = 1'b1;
        lsu_req_addr = a;
        lsu_req_wen = w;
        lsu_req_wdata = d;
        lsu_req_wmask = m;
    endtask

    task automatic drain(input int n);
        p_ifu = 0;
        p_lsu = 0;
        p_ready = 100;
        p_resp = 100;
        repeat (n) tick();
    endtask

    initial begin : stimulus
        int  acc_t, ifu_k, streak, n_ifu;
        bit  got, done;
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = '0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        p_ifu = 0; p_lsu = 0; p_ready = 100; p_resp = 100; fix_en = 0; fix_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single fetch, minimum latency
        fix_en = 1; fix_data = 32'h0000_0413;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        acc_t = -100; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (ifu_acc) acc_t = k;
            if (ifu_rv) begin
                got = 1;
                chk("fetch_latency", k - acc_t, 3);
                chk("fetch_data", ifu_rd_s, 32'h0000_0413);
            end
        end
        if (!got) chk("fetch_timeout", 0, 1);

        // simultaneous IFU + LSU load: LSU first, IFU on the following idle cycle
        fix_data = 32'h1357_9bdf;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        set_lsu(32'h8000_0200, 1'b0, '0, '0);
        ifu_k = -1; got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (k == 0) begin
                chk("both_lsu_first", lsu_acc, 1);
                chk("both_ifu_held", ifu_acc, 0);
            end
            if (ifu_acc) ifu_k = k;
            if (ifu_rv) got = 1;
        end
        chk("both_ifu_next_idle", ifu_k, 3);
        if (!got) chk("both_timeout", 0, 1);

        // store: fields pass through, completion data is zero
        fix_data = 32'hffff_ffff;
        set_lsu(32'h8000_0100, 1'b1, 32'hdead_beef, 4'b0011);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (lsu_rv) begin
                got = 1;
                chk("store_resp_zero", lsu_rd_s, 0);
            end
        end
        if (!got) chk("store_timeout", 0, 1);

        // starvation: IFU continuously valid, LSU flooding
        fix_en = 0;
        p_ifu = 100; p_lsu = 100;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
        set_lsu(32'h8000_0300, 1'b0, '0, '0);
        streak = 0; n_ifu = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (lsu_acc) streak++;
            if (ifu_acc) begin
                chk("starve_streak", streak, LIMIT);
                streak = 0;
                n_ifu++;
            end
        end
        chk("starve_ifu_served", n_ifu > 1, 1);
        drain(30);

        // backpressure: memory not ready for several cycles
        p_ready = 0; p_resp = 100;
        set_lsu(32'h8000_0400, 1'b1, 32'h0bad_f00d, 4'b1100);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (lsu_acc) got = 1;
        end
        if (!got) chk("stall_accept_timeout", 0, 1);
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020;
        repeat (6) begin
            tick();
            chk("stall_no_accept", ifu_acc || lsu_acc, 0);
        end
        drain(20);

        // reset while waiting for the memory response
        p_ready = 100; p_resp = 0;
        set_lsu(32'h8000_0500, 1'b0, '0, '0);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (lsu_acc) got = 1;
        end
        if (!got) chk("rst_accept_timeout", 0, 1);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h1234_5678;
        repeat (5) begin
            tick();
            chk("rst_drop_no_resp", ifu_rv || lsu_rv, 0);
            chk("rst_drop_lsu_data", lsu_rd_s, 0);
        end

        // random traffic with stray responses in every state
        p_ifu = 60; p_lsu = 60; p_ready = 70; p_resp = 50; fix_en = 0;
        repeat (600) tick();
        drain(40);
        done = (exp_mem_q.size() == 0) && (exp_ifu_q.size() == 0) && (exp_lsu_q.size() == 0) && !m_busy;
        chk("drain_empty", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
